// File: rtl/mcs8_pkg.sv
// Shared MCS8 definitions: processor-state codes driven on S2..S0 and the
// machine-cycle length codes supplied by instruction decode.
package mcs8_pkg;

    localparam logic [2:0] ST_T1      = 3'b010;
    localparam logic [2:0] ST_T1I     = 3'b011;
    localparam logic [2:0] ST_T2      = 3'b001;
    localparam logic [2:0] ST_WAIT    = 3'b000;
    localparam logic [2:0] ST_T3      = 3'b100;
    localparam logic [2:0] ST_STOPPED = 3'b110;
    localparam logic [2:0] ST_T4      = 3'b111;
    localparam logic [2:0] ST_T5      = 3'b101;

    // Cycle-length code names the last state of the machine cycle.
    localparam logic [1:0] CL_T4     = 2'd0;
    localparam logic [1:0] CL_T5     = 2'd1;
    localparam logic [1:0] CL_T5_ALT = 2'd2;
    localparam logic [1:0] CL_T3     = 2'd3;

    typedef enum logic [2:0] {
        S_WAIT    = 3'b000,
        S_T2      = 3'b001,
        S_T1      = 3'b010,
        S_T1I     = 3'b011,
        S_T3      = 3'b100,
        S_T5      = 3'b101,
        S_STOPPED = 3'b110,
        S_T4      = 3'b111
    } mcs8_state_e;

    function automatic logic cycle_has_t5(input logic [1:0] cycle_len);
        return (cycle_len == CL_T5) || (cycle_len == CL_T5_ALT);
    endfunction

endpackage

// File: rtl/mcs8_state_timer_if.sv
// Bundle of the sequencer's control inputs and state outputs, shared between
// the clock generator / decode / bus side (master) and the sequencer (slave).
interface mcs8_state_timer_if;

    logic       ph2;
    logic       ready;
    logic       int_req;
    logic       halt;
    logic [1:0] cycle_len;
    logic [2:0] state;
    logic       sync;
    logic       endcyc;
    logic       intack;

    modport master (
        output ph2, ready, int_req, halt, cycle_len,
        input  state, sync, endcyc, intack
    );

    modport slave (
        input  ph2, ready, int_req, halt, cycle_len,
        output state, sync, endcyc, intack
    );

endinterface

// File: rtl/mcs8_state_timer.sv
// 8008 processor-state sequencer: steps T1..T5/WAIT/STOPPED on every second
// phase-2 strobe and reports the S2..S0 code, SYNC and cycle-boundary pulses.
module mcs8_state_timer
    import mcs8_pkg::*;
(
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       PH2_I,
    input  logic       READY_I,
    input  logic       INT_I,
    input  logic       HALT_I,
    input  logic [1:0] CYCLE_LEN_I,
    output logic [2:0] STATE_O,
    output logic       SYNC_O,
    output logic       ENDCYC_O,
    output logic       INTACK_O
);

    logic [2:0] state_q, state_d;
    logic       sync_q, sync_d;
    logic       endcyc_q, endcyc_d;
    logic       intack_q, intack_d;
    logic       int_lat_q, int_lat_d;
    logic       adv;
    logic       cyc_end;
    logic       halt_stop;
    logic       enter_t1i;

    always_comb begin
        state_d   = state_q;
        cyc_end   = 1'b0;
        halt_stop = 1'b0;
        // SYNC high on a PH2 strobe marks the second half of a state.
        adv       = PH2_I & sync_q;

        if (adv) begin
            case (state_q)
                ST_T1, ST_T1I: state_d = ST_T2;
                ST_T2, ST_WAIT: state_d = READY_I ? ST_T3 : ST_WAIT;
                ST_T3: begin
                    if (HALT_I) begin
                        state_d   = ST_STOPPED;
                        halt_stop = 1'b1;
                    end else if (CYCLE_LEN_I == CL_T3) begin
                        cyc_end = 1'b1;
                    end else begin
                        state_d = ST_T4;
                    end
                end
                ST_T4: begin
                    if (cycle_has_t5(CYCLE_LEN_I)) state_d = ST_T5;
                    else                           cyc_end = 1'b1;
                end
                ST_T5: cyc_end = 1'b1;
                ST_STOPPED: begin
                    if (int_lat_q) state_d = ST_T1I;
                end
                default: state_d = ST_STOPPED;
            endcase

            if (cyc_end) state_d = int_lat_q ? ST_T1I : ST_T1;
        end

        enter_t1i = adv && (state_d == ST_T1I) && (state_q != ST_T1I);
        endcyc_d  = cyc_end | halt_stop;
        intack_d  = enter_t1i;
        sync_d    = sync_q ^ PH2_I;
        // Acknowledging consumes the request even if INT_I is still high.
        int_lat_d = enter_t1i ? 1'b0 : (int_lat_q | INT_I);
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= ST_STOPPED;
            sync_q    <= 1'b0;
            endcyc_q  <= 1'b0;
            intack_q  <= 1'b0;
            int_lat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            endcyc_q  <= endcyc_d;
            intack_q  <= intack_d;
            int_lat_q <= int_lat_d;
        end
    end

    assign STATE_O  = state_q;
    assign SYNC_O   = sync_q;
    assign ENDCYC_O = endcyc_q;
    assign INTACK_O = intack_q;

endmodule

// File: tb/tb_mcs8_state_timer.sv
// Bench for mcs8_state_timer: directed scenarios plus randomized traffic,
// all checked against a state-name model driven by the transition rules.
module tb_mcs8_state_timer;

    logic clk;
    logic rst;
    mcs8_state_timer_if bus ();

    mcs8_state_timer dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .PH2_I       (bus.ph2),
        .READY_I     (bus.ready),
        .INT_I       (bus.int_req),
        .HALT_I      (bus.halt),
        .CYCLE_LEN_I (bus.cycle_len),
        .STATE_O     (bus.state),
        .SYNC_O      (bus.sync),
        .ENDCYC_O    (bus.endcyc),
        .INTACK_O    (bus.intack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Clock generator model: PH2 high one cycle in four while running.
    bit ph2_run = 1'b1;
    int ph_div  = 0;

    // Reference model in terms of state names.
    typedef enum {M_T1, M_T1I, M_T2, M_WAIT, M_T3, M_T4, M_T5, M_STOP} mst_e;
    mst_e m_st;
    int   m_strobes;
    bit   m_latch, m_end, m_ack;

    // Snapshot layout: {state[2:0], sync, endcyc, intack}
    logic [5:0] obs_q[$];
    logic [5:0] exp_q[$];

    function automatic logic [2:0] mcode(input mst_e s);
        case (s)
            M_T1:    return 3'b010;
            M_T1I:   return 3'b011;
            M_T2:    return 3'b001;
            M_WAIT:  return 3'b000;
            M_T3:    return 3'b100;
            M_T4:    return 3'b111;
            M_T5:    return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    task automatic model_reset();
        m_st = M_STOP; m_strobes = 0; m_latch = 0; m_end = 0; m_ack = 0;
    endtask

    task automatic model_step();
        bit   adv, fin;
        mst_e nx;
        adv = bus.ph2 && (m_strobes % 2 == 1);
        if (bus.ph2) m_strobes++;
        m_end = 0; m_ack = 0; fin = 0; nx = m_st;
        if (adv) begin
            case (m_st)
                M_T1, M_T1I:  nx = M_T2;
                M_T2, M_WAIT: nx = bus.ready ? M_T3 : M_WAIT;
                M_T3: begin
                    if (bus.halt) begin nx = M_STOP; m_end = 1; end
                    else if (bus.cycle_len == 2'd3) fin = 1;
                    else nx = M_T4;
                end
                M_T4: if (bus.cycle_len == 2'd1 || bus.cycle_len == 2'd2) nx = M_T5; else fin = 1;
                M_T5: fin = 1;
                default: if (m_latch) nx = M_T1I;
            endcase
            if (fin) begin m_end = 1; nx = m_latch ? M_T1I : M_T1; end
            m_ack = (nx == M_T1I);
            m_st  = nx;
        end
        if (m_ack) m_latch = 0;
        else if (bus.int_req) m_latch = 1;
    endtask

    function automatic logic [5:0] snap();
        return {bus.state, bus.sync, bus.endcyc, bus.intack};
    endfunction

    function automatic logic [5:0] mexp();
        return {mcode(m_st), 1'(m_strobes % 2), m_end, m_ack};
    endfunction

    // Called off-edge; applies PH2 for the coming edge and steps the model.
    task automatic tick();
        bus.ph2 = ph2_run && (ph_div == 3);
        if (ph2_run) ph_div = (ph_div + 1) % 4;
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            obs_q.push_back(snap());
            exp_q.push_back(mexp());
        end
    endtask

    task automatic test_reset();
        logic       prev_sync;
        int         toggles;
        rst = 1'b1;
        #2;
        checks++; if (bus.state !== 3'b110) begin failures++; $display("FAIL reset_state got=%b exp=110", bus.state); end
        checks++; if (bus.sync !== 1'b0) begin failures++; $display("FAIL reset_sync got=%b exp=0", bus.sync); end
        checks++; if (bus.endcyc !== 1'b0) begin failures++; $display("FAIL reset_endcyc got=%b exp=0", bus.endcyc); end
        checks++; if (bus.intack !== 1'b0) begin failures++; $display("FAIL reset_intack got=%b exp=0", bus.intack); end
        tick();
        #2 rst = 1'b0;
        obs_q.delete(); exp_q.delete();
        prev_sync = bus.sync;
        run(40);
        toggles = 0;
        for (int i = 0; i < 40; i++) begin
            if (obs_q[i][2] != prev_sync) toggles++;
            prev_sync = obs_q[i][2];
            checks++;
            if (obs_q[i][5:3] !== 3'b110 || obs_q[i][1:0] !== 2'b00) begin
                failures++; $display("FAIL idle_stopped cyc=%0d got=%b exp=110x00", i, obs_q[i]);
            end
        end
        checks++; if (toggles !== 10) begin failures++; $display("FAIL idle_sync_toggles got=%0d exp=10", toggles); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL reset_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_wake_short();
        bit found;
        int b, ends;
        obs_q.delete(); exp_q.delete();
        bus.ready = 1; bus.cycle_len = 2'd3; bus.halt = 0;
        bus.int_req = 1; run(1); bus.int_req = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin run(1); if (bus.intack) found = 1; end
        checks++; if (!found) begin failures++; $display("FAIL wake_intack got=none exp=pulse within 20 cycles"); end
        checks++; if (bus.state !== 3'b011) begin failures++; $display("FAIL wake_t1i got=%b exp=011", bus.state); end
        b = obs_q.size();
        run(24);
        ends = 0;
        for (int o = 0; o < 24; o++) begin
            logic [2:0] want;
            want = (o < 7) ? 3'b011 : (o < 15) ? 3'b001 : (o < 23) ? 3'b100 : 3'b010;
            ends += obs_q[b+o][1];
            checks++; if (obs_q[b+o][5:3] !== want) begin failures++; $display("FAIL wake_seq off=%0d got=%b exp=%b", o, obs_q[b+o][5:3], want); end
        end
        checks++; if (obs_q[b+23][1] !== 1'b1 || ends !== 1) begin failures++; $display("FAIL wake_endcyc got=%0d pulses exp=1 at T3->T1", ends); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL wake_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ready_stall();
        int waits, ends;
        obs_q.delete(); exp_q.delete();
        bus.ready = 0; run(32);
        bus.ready = 1; run(16);
        waits = 0; ends = 0;
        for (int o = 0; o < 48; o++) begin
            logic [2:0] want;
            want = (o < 7) ? 3'b010 : (o < 15) ? 3'b001 : (o < 39) ? 3'b000 : (o < 47) ? 3'b100 : 3'b010;
            if (obs_q[o][5:3] == 3'b000) waits++;
            ends += obs_q[o][1];
            checks++; if (obs_q[o][5:3] !== want) begin failures++; $display("FAIL stall_seq off=%0d got=%b exp=%b", o, obs_q[o][5:3], want); end
        end
        checks++; if (waits !== 24) begin failures++; $display("FAIL stall_wait_len got=%0d exp=24", waits); end
        checks++; if (ends !== 1) begin failures++; $display("FAIL stall_endcyc got=%0d exp=1", ends); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_long_cycle();
        int ends4, ends5;
        obs_q.delete(); exp_q.delete();
        bus.cycle_len = 2'd0; run(32);
        bus.cycle_len = 2'd1; run(40);
        ends4 = 0; ends5 = 0;
        for (int o = 0; o < 32; o++) begin
            logic [2:0] want;
            want = (o < 7) ? 3'b010 : (o < 15) ? 3'b001 : (o < 23) ? 3'b100 : (o < 31) ? 3'b111 : 3'b010;
            ends4 += obs_q[o][1];
            checks++; if (obs_q[o][5:3] !== want) begin failures++; $display("FAIL len4_seq off=%0d got=%b exp=%b", o, obs_q[o][5:3], want); end
        end
        for (int o = 0; o < 40; o++) begin
            logic [2:0] want;
            want = (o < 7) ? 3'b010 : (o < 15) ? 3'b001 : (o < 23) ? 3'b100 : (o < 31) ? 3'b111 : (o < 39) ? 3'b101 : 3'b010;
            ends5 += obs_q[32+o][1];
            checks++; if (obs_q[32+o][5:3] !== want) begin failures++; $display("FAIL len5_seq off=%0d got=%b exp=%b", o, obs_q[32+o][5:3], want); end
        end
        checks++; if (ends4 !== 1) begin failures++; $display("FAIL len4_endcyc got=%0d exp=1", ends4); end
        checks++; if (ends5 !== 1) begin failures++; $display("FAIL len5_endcyc got=%0d exp=1", ends5); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL long_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_halt_int();
        bit found;
        int b;
        obs_q.delete(); exp_q.delete();
        bus.cycle_len = 2'd1; bus.halt = 1; run(24); bus.halt = 0;
        checks++; if (obs_q[23][5:3] !== 3'b110 || obs_q[23][1] !== 1'b1) begin failures++; $display("FAIL halt_stop got=%b exp=110x1x", obs_q[23]); end
        checks++; if (obs_q[22][5:3] !== 3'b100) begin failures++; $display("FAIL halt_from_t3 got=%b exp=100", obs_q[22][5:3]); end
        bus.int_req = 1; run(1); bus.int_req = 0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin run(1); if (bus.intack) found = 1; end
        checks++; if (!found) begin failures++; $display("FAIL halt_wake got=none exp=intack within 20 cycles"); end
        run(24);
        checks++; if (bus.state !== 3'b111) begin failures++; $display("FAIL halt_reach_t4 got=%b exp=111", bus.state); end
        b = obs_q.size();
        bus.int_req = 1; run(1); bus.int_req = 0;
        run(15);
        checks++; if (obs_q[b+7][5:3] !== 3'b101) begin failures++; $display("FAIL int_t5 got=%b exp=101", obs_q[b+7][5:3]); end
        checks++; if (obs_q[b+15] !== 6'b011011 && obs_q[b+15] !== 6'b011111) begin failures++; $display("FAIL int_t1i got=%b exp=011x11", obs_q[b+15]); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL haltint_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_t4();
        int acks;
        obs_q.delete(); exp_q.delete();
        bus.cycle_len = 2'd0; run(24);
        checks++; if (bus.state !== 3'b111) begin failures++; $display("FAIL rst_reach_t4 got=%b exp=111", bus.state); end
        bus.int_req = 1; run(1); bus.int_req = 0;
        run(2);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.state !== 3'b110) begin failures++; $display("FAIL rst_async_state got=%b exp=110", bus.state); end
        checks++; if (bus.sync !== 1'b0) begin failures++; $display("FAIL rst_async_sync got=%b exp=0", bus.sync); end
        model_reset();
        tick();
        #2 rst = 1'b0;
        obs_q.delete(); exp_q.delete();
        run(40);
        acks = 0;
        for (int i = 0; i < 40; i++) acks += obs_q[i][0];
        checks++; if (acks !== 0 || bus.state !== 3'b110) begin failures++; $display("FAIL rst_latch_discard got=%0d acks state=%b exp=0 acks 110", acks, bus.state); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_ph2_freeze();
        logic [5:0] held;
        bit found;
        obs_q.delete(); exp_q.delete();
        held = snap();
        ph2_run = 0;
        run(4); bus.int_req = 1; run(1); bus.int_req = 0; run(15);
        for (int i = 0; i < 20; i++) begin
            checks++; if (obs_q[i][5:2] !== held[5:2]) begin failures++; $display("FAIL freeze_hold cyc=%0d got=%b exp=%b", i, obs_q[i][5:2], held[5:2]); end
        end
        ph2_run = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin run(1); if (bus.intack) found = 1; end
        checks++; if (!found) begin failures++; $display("FAIL freeze_latch_kept got=none exp=intack within 20 cycles"); end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL freeze_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        obs_q.delete(); exp_q.delete();
        for (int i = 0; i < 1500; i++) begin
            bus.ready     = ($urandom_range(0, 3) != 0);
            bus.halt      = ($urandom_range(0, 7) == 0);
            bus.cycle_len = 2'($urandom_range(0, 3));
            bus.int_req   = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) ph2_run = ~ph2_run;
            run(1);
        end
        ph2_run = 1;
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_model cyc=%0d got=%b exp=%b", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ph2 = 0; bus.ready = 0; bus.int_req = 0; bus.halt = 0; bus.cycle_len = 2'd3;
        model_reset();
        test_reset();
        test_wake_short();
        test_ready_stall();
        test_long_cycle();
        test_halt_int();
        test_reset_t4();
        test_ph2_freeze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mcs8_state_timer.md
# mcs8_state_timer

MCS8 processor-state sequencer. Uses the two-phase clock generator's phase-2 strobe to step through the 8008 machine states (T1, T1I, T2, WAIT, T3, T4, T5, STOPPED) and drives the S2..S0 state code and SYNC. It sits between the clock generator and the instruction decode/bus control logic. Decode supplies cycle length and halt, and the bus supplies READY.

## Interface
- No parameters. State encodings and cycle-length codes come from the shared package.
- CLK_I  input  1  master clock; all registers use its rising edge.
- RST_I  input  1  asynchronous, active-high reset.
- PH2_I  input  1  phase-2 strobe from the clock generator, sampled on CLK_I. It is high for one CLK_I cycle in every 4.
- READY_I  input  1  memory/IO ready; sampled at T2 and WAIT advance edges.
- INT_I  input  1  interrupt request, level; sampled every CLK_I cycle.
- HALT_I  input  1  decode reports HLT; sampled at the T3 advance edge.
- CYCLE_LEN_I  input  2  last state of the current machine cycle: 2'd3=T3, 2'd0=T4, 2'd1=T5; 2'd2 is treated as T5.
- STATE_O  output  3  registered S2..S0 code.
- SYNC_O  output  1  registered; toggles on every PH2 strobe.
- ENDCYC_O  output  1  one-CLK_I pulse marking the end of a machine cycle.
- INTACK_O  output  1  one-CLK_I pulse on entry to T1I.

## Operation
- State codes on STATE_O:
  - T1=3'b010
  - T1I=3'b011
  - T2=3'b001
  - WAIT=3'b000
  - T3=3'b100
  - STOPPED=3'b110
  - T4=3'b111
  - T5=3'b101
- Advance edge: a CLK_I edge with PH2_I=1 and SYNC_O=1. State changes only on advance edges.
- Transitions at an advance edge:
  - T1 → T2; T1I → T2.
  - T2 → T3 if READY_I=1, else WAIT.
  - WAIT → T3 if READY_I=1, else stay in WAIT.
  - T3:
    - HALT_I=1 → STOPPED. HALT_I has priority over CYCLE_LEN_I.
    - else CYCLE_LEN_I=3 → cycle end.
    - else → T4.
  - T4 → T5 if CYCLE_LEN_I is 1 or 2, else cycle end.
  - T5 → cycle end.
  - Cycle end: go to T1I if the interrupt latch is set, otherwise T1.
  - STOPPED → T1I if the interrupt latch is set, else stay in STOPPED.
- Interrupt latch:
  - Set on any CLK_I edge with INT_I=1.
  - Cleared on the edge that enters T1I.
  - If INT_I=1 on that same edge, the clear wins. The request is consumed and is not re-latched.
- ENDCYC_O pulses on every advance edge that leaves T3, T4 or T5 toward T1, T1I or STOPPED.
- INTACK_O pulses on every advance edge that enters T1I.
- CYCLE_LEN_I, HALT_I and READY_I are ignored outside the advance edges where they are listed above.

## Timing
- Reset values (asynchronous, immediate):
  - STATE_O=STOPPED (3'b110)
  - SYNC_O=0
  - ENDCYC_O=0
  - INTACK_O=0
  - interrupt latch=0
- SYNC_O toggles on every PH2 edge. After reset the first PH2 drives SYNC_O to 1; the second PH2 drives it to 0 and is an advance edge.
- Each state lasts 2 PH2 strobes, which is 8 CLK_I cycles with the standard clock generator.
- STATE_O, ENDCYC_O and INTACK_O update on the advance edge itself; there is no extra cycle of latency.
- ENDCYC_O and INTACK_O are high for exactly one CLK_I cycle.
- Reset asserted mid-cycle, including in WAIT or T4: all outputs return to reset values at once. After release the block restarts in STOPPED and needs an interrupt to run.
- PH2_I held at 0 freezes all state, including SYNC_O. The interrupt latch keeps capturing INT_I.

## Structure
- Shared package mcs8_pkg holds:
  - the 3-bit state code constants (T1, T1I, T2, WAIT, T3, T4, T5, STOPPED);
  - CYCLE_LEN_I code constants;
  - a state typedef used by decode and bus control.
- Single module with one registered state, SYNC toggle, interrupt latch and pulse registers. No sub-module is natural.

## Test plan
- Reset release, INT_I held 0, 40 CLK_I cycles → STATE_O stays 3'b110, SYNC_O toggles every 4 cycles, no ENDCYC_O or INTACK_O pulses.
- Wake and short cycle:
  - Stimulus: INT_I pulsed 1 cycle while STOPPED, READY_I=1, CYCLE_LEN_I=3.
  - Response: next advance edge enters T1I with INTACK_O pulse, then T2, T3, T1, 8 CLK_I cycles per state.
  - Response: ENDCYC_O pulses on the T3→T1 edge.
- Ready stall: READY_I=0 at T2 for 3 advance edges, then 1 → sequence T2, WAIT×3, T3. WAIT code 3'b000 is held 24 CLK_I cycles.
- Long cycle: CYCLE_LEN_I=0 → T3, T4, T1. CYCLE_LEN_I=1 → T3, T4, T5, T1. ENDCYC_O pulses once per cycle.
- Halt and interrupt timing:
  - HALT_I=1 at T3 with CYCLE_LEN_I=1 → STOPPED. ENDCYC_O pulses.
  - INT_I arriving during T4 of a later cycle → the cycle completes to T5, then enters T1I instead of T1.
- Reset during T4 → STATE_O=3'b110 and SYNC_O=0 within the same cycle, without waiting for a CLK_I edge. A latched interrupt is discarded.
